// File: rtl/dp_arbiter.sv
// Two-requester arbiter that sequences a shared datapath through load/exec/capture.
// Define DP_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (req0 wins).
module dp_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [2:0]       state,
  output logic [WIDTH-1:0] dp_din,
  output logic             dp_we,
  output logic             dp_w1,
  output logic [OPW-1:0]   dp_ms,
  input  logic [WIDTH-1:0] dp_alu
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    EXEC  = 3'd3,
    CAPT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             win_q, win_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             pick;
  logic             active;

`ifdef DP_ARB_RR_EN
  logic last_q, last_d;

  // last_q = 1 means requester 1 was served last, so requester 0 wins the next tie
  assign pick = (req0 & req1) ? ~last_q : ~req0;
`else
  assign pick = ~req0;
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef DP_ARB_RR_EN
    last_d   = last_q;
`endif
    dp_din   = '0;
    dp_we    = 1'b0;
    dp_w1    = 1'b0;
    dp_ms    = '0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          win_d   = pick;
          op_d    = pick ? op1 : op0;
          a_d     = pick ? a1 : a0;
          b_d     = pick ? b1 : b0;
`ifdef DP_ARB_RR_EN
          last_d  = pick;
`endif
          state_d = LOADA;
        end
      end
      LOADA: begin
        dp_din  = a_q;
        dp_we   = 1'b1;
        state_d = LOADB;
      end
      LOADB: begin
        dp_din  = b_q;
        dp_we   = 1'b1;
        dp_w1   = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        dp_ms   = op_q;
        state_d = CAPT;
      end
      CAPT: begin
        dp_ms    = op_q;
        result_d = dp_alu;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef DP_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef DP_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign active = (state_q == LOADA) || (state_q == LOADB) || (state_q == EXEC) ||
                  (state_q == CAPT)  || (state_q == DONE);
  assign gnt0   = active & ~win_q;
  assign gnt1   = active & win_q;
  assign done0  = (state_q == DONE) & ~win_q;
  assign done1  = (state_q == DONE) & win_q;
  assign busy   = (state_q != IDLE);
  assign state  = state_q;
  assign result = result_q;

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: table vectors, corner sequences and random traffic against a transaction model.
module tb_dp_arbiter;

`ifdef DP_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clear;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, busy, dp_we, dp_w1;
  logic [15:0] result, dp_din, dp_alu;
  logic [2:0]  state, dp_ms;

  int n_checks = 0;
  int n_errors = 0;

  dp_arbiter #(.WIDTH(16), .OPW(3)) dut (
    .clk(clk), .clear(clear), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .result(result), .busy(busy), .state(state),
    .dp_din(dp_din), .dp_we(dp_we), .dp_w1(dp_w1), .dp_ms(dp_ms), .dp_alu(dp_alu)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return b;
    endcase
  endfunction

  // external datapath: two operand registers feeding a combinational ALU
  logic [15:0] ra = '0, rb = '0;
  always_ff @(posedge clk) begin
    if (dp_we) begin
      if (dp_w1) rb <= dp_din;
      else       ra <= dp_din;
    end
  end
  assign dp_alu = alu(dp_ms, ra, rb);

  // transaction model: cycles elapsed since the grant, 0 when no transaction is in flight
  int          m_phase;
  logic        m_win, m_last;
  logic [2:0]  m_op;
  logic [15:0] m_a, m_b, m_result;

  task automatic model_reset();
    m_phase = 0; m_win = 1'b0; m_last = 1'b1;
    m_op = '0; m_a = '0; m_b = '0; m_result = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_phase));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("gnt0", 32'(gnt0), 32'(m_phase != 0 && !m_win));
    chk("gnt1", 32'(gnt1), 32'(m_phase != 0 && m_win));
    chk("gnt_mutex", 32'(gnt0 & gnt1), 32'(0));
    chk("done0", 32'(done0), 32'(m_phase == 5 && !m_win));
    chk("done1", 32'(done1), 32'(m_phase == 5 && m_win));
    chk("dp_we", 32'(dp_we), 32'(m_phase == 1 || m_phase == 2));
    if (m_phase == 1 || m_phase == 2) chk("dp_w1", 32'(dp_w1), 32'(m_phase == 2));
    if (m_phase <= 2)
      chk("dp_din", 32'(dp_din), 32'(m_phase == 0 ? 16'h0 : (m_phase == 1 ? m_a : m_b)));
    if (m_phase == 0 || m_phase == 3 || m_phase == 4)
      chk("dp_ms", 32'(dp_ms), 32'(m_phase == 0 ? 3'd0 : m_op));
    chk("result", 32'(result), 32'(m_result));
  endtask

  task automatic step();
    @(posedge clk);
    if (!clear) model_reset();
    else if (m_phase == 0) begin
      if (req0 | req1) begin
        if (req0 && req1) m_win = RR ? ~m_last : 1'b0;
        else              m_win = req1;
        m_last  = m_win;
        m_op    = m_win ? op1 : op0;
        m_a     = m_win ? a1 : a0;
        m_b     = m_win ? b1 : b0;
        m_phase = 1;
      end
    end else if (m_phase == 5) m_phase = 0;
    else begin
      if (m_phase == 4) m_result = alu(m_op, m_a, m_b);
      m_phase++;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    clear = 1'b0; req0 = 0; req1 = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check_all();
    clear = 1'b1;
  endtask

  typedef struct {
    logic r0, r1;
    logic [2:0] op0; logic [15:0] a0, b0;
    logic [2:0] op1; logic [15:0] a1, b1;
    logic win_rr; logic [15:0] res_rr;
    logic win_fx; logic [15:0] res_fx;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 3'd3, 16'h0005, 16'h0003, 3'd0, 16'h0000, 16'h0000, 1'b0, 16'h0007, 1'b0, 16'h0007};
    tbl[1] = '{1'b0, 1'b1, 3'd1, 16'h1111, 16'h2222, 3'd0, 16'h0010, 16'h0020, 1'b1, 16'h0030, 1'b1, 16'h0030};
    tbl[2] = '{1'b1, 1'b1, 3'd1, 16'h0009, 16'h0004, 3'd4, 16'h00FF, 16'h0F0F, 1'b0, 16'h0005, 1'b0, 16'h0005};
    tbl[3] = '{1'b1, 1'b1, 3'd1, 16'h0009, 16'h0004, 3'd4, 16'h00FF, 16'h0F0F, 1'b1, 16'h0FF0, 1'b0, 16'h0005};
    tbl[4] = '{1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000, 3'd6, 16'h8001, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0002};
    tbl[5] = '{1'b1, 1'b1, 3'd2, 16'hF0F0, 16'hFF00, 3'd5, 16'h1234, 16'h0000, 1'b0, 16'hF000, 1'b0, 16'hF000};

    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      op0 = tbl[i].op0; a0 = tbl[i].a0; b0 = tbl[i].b0;
      op1 = tbl[i].op1; a1 = tbl[i].a1; b1 = tbl[i].b1;
      step();
      req0 = 0; req1 = 0;
      repeat (4) step();
      if ((RR ? tbl[i].win_rr : tbl[i].win_fx) == 1'b0) chk("tbl_done0", 32'(done0), 32'(1));
      else                                              chk("tbl_done1", 32'(done1), 32'(1));
      chk("tbl_result", 32'(result), 32'(RR ? tbl[i].res_rr : tbl[i].res_fx));
      step();
    end

    // tie from reset, both held: second grant follows straight after DONE
    do_reset();
    req0 = 1; req1 = 1; op0 = 3'd0; op1 = 3'd1;
    a0 = 16'h0100; b0 = 16'h0001; a1 = 16'h0100; b1 = 16'h0001;
    step();
    chk("tie_first_gnt0", 32'(gnt0), 32'(1));
    repeat (6) step();
    chk("tie_second_gnt1", 32'(gnt1), 32'(RR));
    chk("tie_second_gnt0", 32'(gnt0), 32'(!RR));
    repeat (6) step();
    chk("tie_third_gnt0", 32'(gnt0), 32'(1));
    req0 = 0; req1 = 0;
    repeat (6) step();

    // operand change after grant must not disturb the transaction in flight
    req0 = 1; op0 = 3'd0; a0 = 16'h1111; b0 = 16'h2222;
    step();
    req0 = 0;
    step();
    a0 = 16'hFFFF; b0 = 16'hFFFF;
    chk("hold_din_b", 32'(dp_din), 32'(16'h2222));
    repeat (3) step();
    chk("hold_result", 32'(result), 32'(16'h3333));
    chk("hold_done0", 32'(done0), 32'(1));
    step();

    // asynchronous abort during EXEC
    req0 = 1; op0 = 3'd4; a0 = 16'hAAAA; b0 = 16'h5555;
    step();
    req0 = 0;
    repeat (2) step();
    chk("abort_in_exec", 32'(state), 32'(3));
    #1 clear = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("abort_result", 32'(result), 32'(0));
    repeat (2) step();
    clear = 1'b1;
    repeat (8) step();
    chk("abort_idle", 32'(state), 32'(0));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      op0 = 3'($urandom); op1 = 3'($urandom);
      a0 = 16'($urandom); b0 = 16'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
